// File: rtl/pairing_pkg.sv
// Shared types and constants for the pairing core command issuer.
package pairing_pkg;
  typedef logic [3:0] func_t;

  localparam func_t FUNC_SRST = 4'hF;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_END, DRAIN, SRST} issuer_state_t;
endpackage

// File: rtl/pairing_cmd_fifo.sv
// Synchronous command FIFO with registered count/full/empty and a flush input.
module pairing_cmd_fifo
  import pairing_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  logic  flush,
  input  func_t wdata,
  output func_t rdata,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);

  func_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count, count_next;
  logic           do_push, do_pop;

  // Push is qualified by the registered full flag, so a same-cycle pop never makes room.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/pairing_cmd_issuer.sv
// Host-side initiator: queues function codes and launches them one at a time on the
// pairing core, with a watchdog, soft reset sequencing and completion reporting.
module pairing_cmd_issuer
  import pairing_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int SWRST_CYC   = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_func,
  input  logic             soft_reset_req,
  input  logic             err_clr,
  output logic             core_swrst,
  output logic             core_run,
  output logic [3:0]       core_n_func,
  input  logic             core_opstart,
  input  logic             core_busy,
  input  logic             core_endflag,
  output logic             done_valid,
  output logic [3:0]       done_func,
  output logic             timeout_err,
  output logic             idle,
  output logic [CNT_W-1:0] done_count
);
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  localparam int SR_W = $clog2(SWRST_CYC + 1);

  issuer_state_t   state;
  func_t           code, head;
  logic [WD_W-1:0] wdog;
  logic [SR_W-1:0] srst_cnt;
  logic            srst_is_cmd;
  logic            fifo_full, fifo_empty, push, pop, wd_expired;

  assign push       = cmd_valid & ~fifo_full & ~soft_reset_req;
  assign pop        = (state == IDLE) & ~fifo_empty & ~soft_reset_req;
  assign cmd_ready  = ~fifo_full;
  assign wd_expired = (wdog == WD_W'(TIMEOUT_CYC - 1));

  pairing_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (soft_reset_req),
    .wdata (cmd_func),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      code        <= '0;
      wdog        <= '0;
      srst_cnt    <= '0;
      srst_is_cmd <= 1'b0;
      core_swrst  <= 1'b0;
      core_run    <= 1'b0;
      core_n_func <= '0;
      done_valid  <= 1'b0;
      done_func   <= '0;
      timeout_err <= 1'b0;
      idle        <= 1'b1;
      done_count  <= '0;
    end else begin
      done_valid <= 1'b0;
      idle       <= (state == IDLE) && fifo_empty;
      if (err_clr) timeout_err <= 1'b0;

      if (soft_reset_req) begin
        state       <= SRST;
        core_run    <= 1'b0;
        core_swrst  <= 1'b1;
        srst_cnt    <= '0;
        srst_is_cmd <= 1'b0;
      end else begin
        case (state)
          IDLE: if (!fifo_empty) begin
            code <= head;
            if (head == FUNC_SRST) begin
              state       <= SRST;
              core_swrst  <= 1'b1;
              srst_cnt    <= '0;
              srst_is_cmd <= 1'b1;
            end else begin
              state       <= LAUNCH;
              core_run    <= 1'b1;
              core_n_func <= head;
              wdog        <= '0;
            end
          end
          LAUNCH: begin
            wdog <= wdog + 1'b1;
            if (core_opstart) begin
              core_run <= 1'b0;
              if (core_endflag) begin
                state      <= DRAIN;
                done_valid <= 1'b1;
                done_func  <= code;
                done_count <= done_count + 1'b1;
              end else begin
                state <= WAIT_END;
              end
            end else if (wd_expired) begin
              state       <= SRST;
              core_run    <= 1'b0;
              core_swrst  <= 1'b1;
              srst_cnt    <= '0;
              srst_is_cmd <= 1'b0;
              timeout_err <= 1'b1;
            end
          end
          WAIT_END: begin
            wdog <= wdog + 1'b1;
            if (core_endflag) begin
              state      <= DRAIN;
              done_valid <= 1'b1;
              done_func  <= code;
              done_count <= done_count + 1'b1;
            end else if (wd_expired) begin
              state       <= SRST;
              core_swrst  <= 1'b1;
              srst_cnt    <= '0;
              srst_is_cmd <= 1'b0;
              timeout_err <= 1'b1;
            end
          end
          DRAIN: if (!core_busy) state <= IDLE;
          SRST: begin
            // srst_cnt saturates at SWRST_CYC once the reset pulse is complete.
            if (srst_cnt != SR_W'(SWRST_CYC)) begin
              srst_cnt <= srst_cnt + 1'b1;
              if (srst_cnt == SR_W'(SWRST_CYC - 1)) core_swrst <= 1'b0;
            end else if (!core_busy) begin
              state <= IDLE;
              if (srst_is_cmd) begin
                done_valid <= 1'b1;
                done_func  <= FUNC_SRST;
                done_count <= done_count + 1'b1;
              end
              srst_is_cmd <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pairing_cmd_issuer.sv
// Directed self-checking bench for pairing_cmd_issuer (TIMEOUT_CYC shortened to 64).
module tb_pairing_cmd_issuer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, soft_reset_req, err_clr;
  logic [3:0]  cmd_func, core_n_func, done_func;
  logic        core_swrst, core_run, core_opstart, core_busy, core_endflag;
  logic        done_valid, timeout_err, idle;
  logic [15:0] done_count;

  int nvec = 0, nerr = 0, exp_count = 0;
  int dv_cnt = 0, swrst_cyc = 0;

  pairing_cmd_issuer #(.FIFO_DEPTH(8), .TIMEOUT_CYC(64), .SWRST_CYC(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
    .soft_reset_req(soft_reset_req), .err_clr(err_clr), .core_swrst(core_swrst),
    .core_run(core_run), .core_n_func(core_n_func), .core_opstart(core_opstart),
    .core_busy(core_busy), .core_endflag(core_endflag), .done_valid(done_valid),
    .done_func(done_func), .timeout_err(timeout_err), .idle(idle), .done_count(done_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done_valid) dv_cnt <= dv_cnt + 1;
    if (core_swrst) swrst_cyc <= swrst_cyc + 1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [3:0] f);
    cmd_valid = 1'b1; cmd_func = f; tick(); cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 0; cmd_func = 0; soft_reset_req = 0; err_clr = 0;
    core_opstart = 0; core_busy = 0; core_endflag = 0;
    tick(); tick(); rst = 1'b0; tick();
    nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL reset cmd_ready got %b want 1", cmd_ready); end
    nvec++; if (idle !== 1'b1) begin nerr++; $display("FAIL reset idle got %b want 1", idle); end
    nvec++; if ({core_swrst, core_run, core_n_func, done_valid, done_func, timeout_err} !== 12'h0)
      begin nerr++; $display("FAIL reset outputs got %b %b %h %b %h %b want all 0", core_swrst, core_run, core_n_func, done_valid, done_func, timeout_err); end
    nvec++; if (done_count !== 16'd0) begin nerr++; $display("FAIL reset done_count got %0d want 0", done_count); end
  endtask

  task automatic test_basic();
    push(4'd3);                                   // now cycle 1
    tick();                                       // cycle 2
    nvec++; if (core_run !== 1'b1 || core_n_func !== 4'd3) begin nerr++; $display("FAIL basic launch run=%b func=%h want 1/3", core_run, core_n_func); end
    core_busy = 1'b1; tick(); tick(); tick();     // cycle 5
    core_opstart = 1'b1; tick(); core_opstart = 1'b0;  // cycle 6
    nvec++; if (core_run !== 1'b0) begin nerr++; $display("FAIL basic run_drop got %b want 0", core_run); end
    nvec++; if (core_n_func !== 4'd3) begin nerr++; $display("FAIL basic n_func_hold got %h want 3", core_n_func); end
    for (int i = 6; i < 20; i++) tick();          // cycle 20
    core_endflag = 1'b1; tick(); core_endflag = 1'b0; core_busy = 1'b0;  // cycle 21
    exp_count++;
    nvec++; if (done_valid !== 1'b1 || done_func !== 4'd3) begin nerr++; $display("FAIL basic done got v=%b f=%h want 1/3", done_valid, done_func); end
    nvec++; if (done_count !== 16'(exp_count)) begin nerr++; $display("FAIL basic done_count got %0d want %0d", done_count, exp_count); end
    tick(); tick();                               // cycle 23
    nvec++; if (idle !== 1'b1) begin nerr++; $display("FAIL basic idle got %b want 1", idle); end
  endtask

  task automatic test_fifo_full();
    push(4'd1); tick();                           // cmd 1 stalled in LAUNCH
    for (int i = 0; i < 8; i++) begin
      nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL full accept%0d cmd_ready got %b want 1", i, cmd_ready); end
      push(4'(i));
    end
    cmd_valid = 1'b1; cmd_func = 4'd9;
    nvec++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL full ninth_held got %b want 0", cmd_ready); end
    tick(); tick();
    nvec++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL full still_held got %b want 0", cmd_ready); end
    core_opstart = 1'b1; core_endflag = 1'b1; tick(); core_opstart = 1'b0; core_endflag = 1'b0;
    exp_count++;
    nvec++; if (done_valid !== 1'b1 || done_func !== 4'd1) begin nerr++; $display("FAIL full done1 got v=%b f=%h want 1/1", done_valid, done_func); end
    nvec++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL full drain_ready got %b want 0", cmd_ready); end
    tick();
    nvec++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL full idle_ready got %b want 0", cmd_ready); end
    tick();
    nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL full after_pop got %b want 1", cmd_ready); end
    tick(); cmd_valid = 1'b0;
    nvec++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL full refull got %b want 0", cmd_ready); end
    soft_reset_req = 1'b1; tick(); soft_reset_req = 1'b0;
    for (int i = 0; i < 20 && idle !== 1'b1; i++) tick();
    nvec++; if (idle !== 1'b1 || cmd_ready !== 1'b1) begin nerr++; $display("FAIL full cleanup idle=%b ready=%b want 1/1", idle, cmd_ready); end
  endtask

  task automatic test_timeout();
    int n, dvb, swb;
    dvb = dv_cnt; swb = swrst_cyc;
    push(4'd6);                                   // cycle 1
    n = 0;
    while (timeout_err !== 1'b1 && n < 100) begin tick(); n++; end
    nvec++; if (n != 65) begin nerr++; $display("FAIL timeout latency got %0d want 65", n); end
    nvec++; if (timeout_err !== 1'b1 || core_swrst !== 1'b1 || core_run !== 1'b0)
      begin nerr++; $display("FAIL timeout state err=%b swrst=%b run=%b want 1/1/0", timeout_err, core_swrst, core_run); end
    for (int i = 0; i < 20 && idle !== 1'b1; i++) tick();
    nvec++; if (swrst_cyc - swb != 4) begin nerr++; $display("FAIL timeout swrst_cycles got %0d want 4", swrst_cyc - swb); end
    nvec++; if (dv_cnt != dvb) begin nerr++; $display("FAIL timeout done_pulses got %0d want 0", dv_cnt - dvb); end
    nvec++; if (timeout_err !== 1'b1) begin nerr++; $display("FAIL timeout sticky got %b want 1", timeout_err); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    nvec++; if (timeout_err !== 1'b0) begin nerr++; $display("FAIL timeout err_clr got %b want 0", timeout_err); end
  endtask

  task automatic test_srst_cmd();
    int swb;
    push(4'd2); push(4'hF); push(4'd5);
    for (int i = 0; i < 10 && core_run !== 1'b1; i++) tick();
    nvec++; if (core_run !== 1'b1 || core_n_func !== 4'd2) begin nerr++; $display("FAIL srst launch2 run=%b func=%h want 1/2", core_run, core_n_func); end
    core_opstart = 1'b1; core_busy = 1'b1; tick(); core_opstart = 1'b0; tick();
    core_endflag = 1'b1; tick(); core_endflag = 1'b0; core_busy = 1'b0;
    exp_count++;
    nvec++; if (done_valid !== 1'b1 || done_func !== 4'd2) begin nerr++; $display("FAIL srst done2 got v=%b f=%h want 1/2", done_valid, done_func); end
    swb = swrst_cyc; tick();
    for (int i = 0; i < 30 && done_valid !== 1'b1; i++) tick();
    exp_count++;
    nvec++; if (done_valid !== 1'b1 || done_func !== 4'hF) begin nerr++; $display("FAIL srst doneF got v=%b f=%h want 1/f", done_valid, done_func); end
    nvec++; if (swrst_cyc - swb != 4) begin nerr++; $display("FAIL srst swrst_cycles got %0d want 4", swrst_cyc - swb); end
    for (int i = 0; i < 10 && core_run !== 1'b1; i++) tick();
    nvec++; if (core_run !== 1'b1 || core_n_func !== 4'd5) begin nerr++; $display("FAIL srst launch5 run=%b func=%h want 1/5", core_run, core_n_func); end
    core_opstart = 1'b1; core_endflag = 1'b1; tick(); core_opstart = 1'b0; core_endflag = 1'b0;
    exp_count++;
    nvec++; if (done_valid !== 1'b1 || done_func !== 4'd5) begin nerr++; $display("FAIL srst done5 got v=%b f=%h want 1/5", done_valid, done_func); end
    nvec++; if (done_count !== 16'(exp_count)) begin nerr++; $display("FAIL srst done_count got %0d want %0d", done_count, exp_count); end
    for (int i = 0; i < 10 && idle !== 1'b1; i++) tick();
  endtask

  task automatic test_soft_reset();
    int dvb, swb;
    push(4'd7);
    for (int i = 0; i < 10 && core_run !== 1'b1; i++) tick();
    core_opstart = 1'b1; core_busy = 1'b1; tick(); core_opstart = 1'b0;
    push(4'd10); push(4'd11); push(4'd12);
    dvb = dv_cnt; swb = swrst_cyc;
    soft_reset_req = 1'b1; tick(); soft_reset_req = 1'b0;
    nvec++; if (core_swrst !== 1'b1 || core_run !== 1'b0) begin nerr++; $display("FAIL softrst enter swrst=%b run=%b want 1/0", core_swrst, core_run); end
    for (int i = 0; i < 6; i++) tick();
    core_busy = 1'b0;
    for (int i = 0; i < 20 && idle !== 1'b1; i++) tick();
    nvec++; if (idle !== 1'b1) begin nerr++; $display("FAIL softrst idle got %b want 1", idle); end
    nvec++; if (swrst_cyc - swb != 4) begin nerr++; $display("FAIL softrst swrst_cycles got %0d want 4", swrst_cyc - swb); end
    tick(); tick(); tick();
    nvec++; if (core_run !== 1'b0 || idle !== 1'b1) begin nerr++; $display("FAIL softrst flushed run=%b idle=%b want 0/1", core_run, idle); end
    nvec++; if (dv_cnt != dvb) begin nerr++; $display("FAIL softrst done_pulses got %0d want 0", dv_cnt - dvb); end
    nvec++; if (done_count !== 16'(exp_count)) begin nerr++; $display("FAIL softrst done_count got %0d want %0d", done_count, exp_count); end
  endtask

  task automatic test_async_reset();
    push(4'd9);
    for (int i = 0; i < 10 && core_run !== 1'b1; i++) tick();
    core_opstart = 1'b1; core_busy = 1'b1; tick(); core_opstart = 1'b0; tick();
    #2 rst = 1'b1; #1;                            // no clock edge in between
    nvec++; if (core_run !== 1'b0 || core_n_func !== 4'd0 || core_swrst !== 1'b0)
      begin nerr++; $display("FAIL async core_if run=%b func=%h swrst=%b want 0/0/0", core_run, core_n_func, core_swrst); end
    nvec++; if (done_count !== 16'd0 || idle !== 1'b1 || cmd_ready !== 1'b1)
      begin nerr++; $display("FAIL async host_if count=%0d idle=%b ready=%b want 0/1/1", done_count, idle, cmd_ready); end
    core_busy = 1'b0; tick(); rst = 1'b0; tick();
    nvec++; if (idle !== 1'b1 || core_run !== 1'b0) begin nerr++; $display("FAIL async release idle=%b run=%b want 1/0", idle, core_run); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fifo_full();
    test_timeout();
    test_srst_cmd();
    test_soft_reset();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
